// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Bundle of the two producer byte ports (valid/ready/data), the
//            UartTx launch/busy pair and the arbiter status outputs.
// Modports : master - producers and UartTx side (drive valid/data/tx_busy)
//            slave  - arbiter side (drives ready, tx_start, sdata,
//                     grant_id, idle)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] sdata;
   logic       grant_id;
   logic       idle;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
      input  req0_ready, req1_ready, tx_start, sdata, grant_id, idle
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
      output req0_ready, req1_ready, tx_start, sdata, grant_id, idle
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UartTx byte transmitter between two byte producers.
//            Each producer port has its own DEPTH-entry FIFO; an FSM pops
//            one byte at a time, pulses tx_start and follows tx_busy so that
//            launches never overlap.
// Ports    : clock  - system clock, rising edge
//            reset  - synchronous, active-high
//            bus    - uart_tx_arbiter_if.slave (req0/req1 valid/ready/data,
//                     tx_busy in; tx_start, sdata, grant_id, idle out)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int DEPTH        = 4,    // entries per port FIFO, power of two
   parameter bit ROUND_ROBIN  = 1'b1, // 1 = alternate, 0 = port 0 priority
   parameter int BUSY_TIMEOUT = 4     // cycles to wait for tx_busy to rise
) (
   input wire                clock,
   input wire                reset,
   uart_tx_arbiter_if.slave  bus
);

   localparam int c_addr_w = $clog2(DEPTH);
   localparam int c_cnt_w  = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t               r_state;
   logic                 r_tx_start;
   logic [7:0]           r_sdata;
   logic                 r_grant_id;
   logic                 r_favour;     // port preferred when both are pending
   logic [c_cnt_w-1:0]   r_cnt;

   logic [1:0]           w_valid;
   logic [1:0][7:0]      w_din;
   logic [1:0][7:0]      w_head;
   logic [1:0]           w_empty;
   logic [1:0]           w_full;
   logic [1:0]           w_pop;
   logic                 w_launch;
   logic                 w_sel;

   assign w_valid = {bus.req1_valid, bus.req0_valid};
   assign w_din   = {bus.req1_data,  bus.req0_data};

   // ------------------------------------------------------------------------
   // Per-port FIFOs. Pointers carry one extra wrap bit so full and empty can
   // be told apart when the index bits match.
   // ------------------------------------------------------------------------
   for (genvar gp = 0; gp < 2; gp++) begin : g_fifo
      logic [7:0]          r_mem [DEPTH];
      logic [c_addr_w:0]   r_wptr;
      logic [c_addr_w:0]   r_rptr;
      logic                w_push;

      assign w_empty[gp] = (r_wptr == r_rptr);
      assign w_full[gp]  = (r_wptr[c_addr_w] != r_rptr[c_addr_w]) &&
                           (r_wptr[c_addr_w-1:0] == r_rptr[c_addr_w-1:0]);
      // Ready comes from registered pointers only, so a push is never
      // offered into a full FIFO even when a pop happens the same cycle.
      assign w_push      = w_valid[gp] && !w_full[gp];
      assign w_head[gp]  = r_mem[r_rptr[c_addr_w-1:0]];

      always_ff @(posedge clock) begin
         if (w_push) begin
            r_mem[r_wptr[c_addr_w-1:0]] <= w_din[gp];
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push) begin
               r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop[gp]) begin
               r_rptr <= r_rptr + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Arbitration. Emptiness is taken from registered pointers, so a byte
   // pushed this cycle cannot be picked until the next one.
   // ------------------------------------------------------------------------
   always_comb begin
      w_sel = 1'b0;
      if (!w_empty[0] && !w_empty[1]) begin
         w_sel = ROUND_ROBIN ? r_favour : 1'b0;
      end else if (w_empty[0]) begin
         w_sel = 1'b1;
      end
   end

   assign w_launch = (r_state == S_IDLE) && !bus.tx_busy && !(&w_empty);
   assign w_pop    = {w_launch && w_sel, w_launch && !w_sel};

   // ------------------------------------------------------------------------
   // Launch FSM. tx_start is high exactly while in START; sdata and grant_id
   // load only on the IDLE->START transition.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_tx_start <= 1'b0;
         r_sdata    <= 8'h00;
         r_grant_id <= 1'b0;
         r_favour   <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_tx_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_launch) begin
                  r_sdata    <= w_head[w_sel];
                  r_grant_id <= w_sel;
                  r_favour   <= ~w_sel;
                  r_tx_start <= 1'b1;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               // A launch that never raises tx_busy is abandoned, not retried.
               if (bus.tx_busy) begin
                  r_state <= S_WAIT_DONE;
               end else if (r_cnt == c_cnt_w'(BUSY_TIMEOUT - 1)) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req0_ready = !w_full[0];
   assign bus.req1_ready = !w_full[1];
   assign bus.tx_start   = r_tx_start;
   assign bus.sdata      = r_sdata;
   assign bus.grant_id   = r_grant_id;
   assign bus.idle       = (r_state == S_IDLE) && (&w_empty);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter. Two DUTs run
//            side by side on the same producer stimulus: dut_rr (round robin)
//            and dut_fp (fixed priority). Each has its own UartTx busy model
//            and launch log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic       r0v = 1'b0, r1v = 1'b0;
   logic [7:0] r0d = 8'h00, r1d = 8'h00;
   logic       busy_force = 1'b0;
   logic       busy_auto  = 1'b0;
   int         busy_len   = 3;
   int         m_t_rr = 0, m_t_fp = 0;

   uart_tx_arbiter_if bus_rr ();
   uart_tx_arbiter_if bus_fp ();

   assign bus_rr.req0_valid = r0v;
   assign bus_rr.req0_data  = r0d;
   assign bus_rr.req1_valid = r1v;
   assign bus_rr.req1_data  = r1d;
   assign bus_fp.req0_valid = r0v;
   assign bus_fp.req0_data  = r0d;
   assign bus_fp.req1_valid = r1v;
   assign bus_fp.req1_data  = r1d;

   // UartTx model: busy rises 2 cycles after the tx_start cycle and stays
   // high for busy_len cycles.
   assign bus_rr.tx_busy = busy_force | ((m_t_rr >= 2) && (m_t_rr < 2 + busy_len));
   assign bus_fp.tx_busy = busy_force | ((m_t_fp >= 2) && (m_t_fp < 2 + busy_len));

   always @(posedge clock) begin
      if (!busy_auto)            m_t_rr <= 0;
      else if (bus_rr.tx_start)  m_t_rr <= 1;
      else if (m_t_rr != 0)      m_t_rr <= (m_t_rr >= 1 + busy_len) ? 0 : m_t_rr + 1;
   end

   always @(posedge clock) begin
      if (!busy_auto)            m_t_fp <= 0;
      else if (bus_fp.tx_start)  m_t_fp <= 1;
      else if (m_t_fp != 0)      m_t_fp <= (m_t_fp >= 1 + busy_len) ? 0 : m_t_fp + 1;
   end

   uart_tx_arbiter #(.DEPTH(4), .ROUND_ROBIN(1'b1), .BUSY_TIMEOUT(4)) dut_rr (
      .clock (clock),
      .reset (reset),
      .bus   (bus_rr)
   );

   uart_tx_arbiter #(.DEPTH(4), .ROUND_ROBIN(1'b0), .BUSY_TIMEOUT(4)) dut_fp (
      .clock (clock),
      .reset (reset),
      .bus   (bus_fp)
   );

   // Launch logs, sampled on the falling edge.
   logic [7:0] q_rr_d[$], q_fp_d[$];
   logic       q_rr_g[$], q_fp_g[$];
   int         q_rr_c[$], q_fp_c[$];

   always @(negedge clock) begin
      if (bus_rr.tx_start === 1'b1) begin
         q_rr_d.push_back(bus_rr.sdata);
         q_rr_g.push_back(bus_rr.grant_id);
         q_rr_c.push_back(cyc);
      end
      if (bus_fp.tx_start === 1'b1) begin
         q_fp_d.push_back(bus_fp.sdata);
         q_fp_g.push_back(bus_fp.grant_id);
         q_fp_c.push_back(cyc);
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic clear_logs();
      q_rr_d.delete(); q_rr_g.delete(); q_rr_c.delete();
      q_fp_d.delete(); q_fp_g.delete(); q_fp_c.delete();
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1; r0v = 1'b0; r1v = 1'b0;
      busy_force = 1'b0; busy_auto = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      clear_logs();
   endtask

   // Offers one byte on port 0; acc_cyc is the cyc value right after the
   // accepting edge.
   task automatic push0(input logic [7:0] d, output int acc_cyc);
      r0v = 1'b1;
      r0d = d;
      for (int i = 0; i < 50 && bus_rr.req0_ready !== 1'b1; i++) tick();
      acc_cyc = cyc + 1;
      tick();
      r0v = 1'b0;
   endtask

   task automatic wait_rr(input int n, input int limit, output bit ok);
      for (int i = 0; i < limit && q_rr_d.size() < n; i++) tick();
      ok = (q_rr_d.size() >= n);
   endtask

   task automatic wait_fp(input int n, input int limit, output bit ok);
      for (int i = 0; i < limit && q_fp_d.size() < n; i++) tick();
      ok = (q_fp_d.size() >= n);
   endtask

   task automatic preload_both();
      busy_force = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         r0v = 1'b1; r0d = 8'(8'h10 + i);
         r1v = 1'b1; r1d = 8'(8'h20 + i);
         tick();
      end
      r0v = 1'b0; r1v = 1'b0;
      tick();
      clear_logs();
      busy_len   = 3;
      busy_auto  = 1'b1;
      busy_force = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      tick();
      reset = 1'b1;
      tick(); tick();
      n_cmp++; if (bus_rr.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", bus_rr.tx_start); end
      n_cmp++; if (bus_rr.sdata !== 8'h00) begin n_fail++; $display("FAIL reset_sdata: got %h want 00", bus_rr.sdata); end
      n_cmp++; if (bus_rr.grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id: got %b want 0", bus_rr.grant_id); end
      n_cmp++; if (bus_rr.req0_ready !== 1'b1 || bus_rr.req1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b%b want 11", bus_rr.req1_ready, bus_rr.req0_ready); end
      n_cmp++; if (bus_rr.idle !== 1'b1 || bus_fp.idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got rr=%b fp=%b want 1", bus_rr.idle, bus_fp.idle); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_byte();
      int  acc, t_idle;
      bit  ok;
      do_reset();
      busy_len  = 20;
      busy_auto = 1'b1;
      tick();
      push0(8'h41, acc);
      wait_rr(1, 20, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_start_seen: got %0d starts want 1", q_rr_d.size()); end
      if (ok) begin
         // accepted at edge k -> tx_start in the cycle after edge k+1
         n_cmp++; if (q_rr_c[0] - acc !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", q_rr_c[0] - acc); end
         n_cmp++; if (q_rr_d[0] !== 8'h41) begin n_fail++; $display("FAIL single_sdata: got %h want 41", q_rr_d[0]); end
         n_cmp++; if (q_rr_g[0] !== 1'b0) begin n_fail++; $display("FAIL single_grant: got %b want 0", q_rr_g[0]); end
      end
      tick(); tick(); tick();
      n_cmp++; if (bus_rr.idle !== 1'b0) begin n_fail++; $display("FAIL single_busy_not_idle: got %b want 0", bus_rr.idle); end
      for (int i = 0; i < 40 && bus_rr.idle !== 1'b1; i++) tick();
      t_idle = cyc;
      // busy high 20 cycles from start+2, WAIT_DONE leaves one cycle later
      n_cmp++; if (bus_rr.idle !== 1'b1 || q_rr_c.size() < 1 || t_idle - q_rr_c[0] !== 23) begin
         n_fail++; $display("FAIL single_idle_return: got idle=%b after %0d cycles want idle=1 after 23", bus_rr.idle, t_idle - ((q_rr_c.size() > 0) ? q_rr_c[0] : 0)); end
      tick(); tick();
      n_cmp++; if (q_rr_d.size() !== 1) begin n_fail++; $display("FAIL single_one_pulse: got %0d want 1", q_rr_d.size()); end
   endtask

   task automatic test_contention();
      logic [7:0] exp_d [6];
      logic       exp_g [6];
      bit         ok;
      exp_d = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      preload_both();
      wait_rr(6, 150, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rr_count: got %0d want 6", q_rr_d.size()); end
      for (int i = 0; i < 6 && i < q_rr_d.size(); i++) begin
         n_cmp++; if (q_rr_d[i] !== exp_d[i] || q_rr_g[i] !== exp_g[i]) begin
            n_fail++; $display("FAIL rr_byte%0d: got %h/g%b want %h/g%b", i, q_rr_d[i], q_rr_g[i], exp_d[i], exp_g[i]); end
      end
      // busy rises 1 cycle late and is high 3 cycles: spacing 4 + 3
      if (q_rr_c.size() >= 2) begin
         n_cmp++; if (q_rr_c[1] - q_rr_c[0] !== 7) begin n_fail++; $display("FAIL rr_spacing: got %0d want 7", q_rr_c[1] - q_rr_c[0]); end
      end
   endtask

   task automatic test_fixed_priority();
      logic [7:0] exp_d [6];
      logic       exp_g [6];
      bit         ok;
      exp_d = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
      exp_g = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      preload_both();
      wait_fp(6, 150, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL fp_count: got %0d want 6", q_fp_d.size()); end
      for (int i = 0; i < 6 && i < q_fp_d.size(); i++) begin
         n_cmp++; if (q_fp_d[i] !== exp_d[i] || q_fp_g[i] !== exp_g[i]) begin
            n_fail++; $display("FAIL fp_byte%0d: got %h/g%b want %h/g%b", i, q_fp_d[i], q_fp_g[i], exp_d[i], exp_g[i]); end
      end
   endtask

   task automatic test_backpressure();
      int acc;
      bit ok;
      do_reset();
      busy_len   = 2;
      busy_auto  = 1'b1;
      busy_force = 1'b1;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus_rr.req1_ready === 1'b1) begin
            r1v = 1'b1; r1d = 8'(8'h30 + acc); acc++;
         end else begin
            r1v = 1'b0;
         end
         tick();
      end
      r1v = 1'b0;
      n_cmp++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", acc); end
      n_cmp++; if (bus_rr.req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", bus_rr.req1_ready); end
      n_cmp++; if (q_rr_d.size() !== 0) begin n_fail++; $display("FAIL bp_no_launch: got %0d want 0", q_rr_d.size()); end
      busy_force = 1'b0;
      wait_rr(1, 20, ok);
      n_cmp++; if (!ok || bus_rr.req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b want 1", bus_rr.req1_ready); end
      wait_rr(4, 100, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 4", q_rr_d.size()); end
      for (int i = 0; i < 4 && i < q_rr_d.size(); i++) begin
         n_cmp++; if (q_rr_d[i] !== 8'(8'h30 + i) || q_rr_g[i] !== 1'b1) begin
            n_fail++; $display("FAIL bp_byte%0d: got %h/g%b want %h/g1", i, q_rr_d[i], q_rr_g[i], 8'(8'h30 + i)); end
      end
   endtask

   task automatic test_timeout();
      int acc;
      bit ok;
      do_reset();
      push0(8'hAA, acc);
      push0(8'hBB, acc);
      wait_rr(2, 40, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL to_count: got %0d want 2", q_rr_d.size()); end
      if (ok) begin
         n_cmp++; if (q_rr_d[0] !== 8'hAA || q_rr_d[1] !== 8'hBB) begin n_fail++; $display("FAIL to_bytes: got %h %h want aa bb", q_rr_d[0], q_rr_d[1]); end
         // START, 4 WAIT_BUSY cycles, IDLE, START
         n_cmp++; if (q_rr_c[1] - q_rr_c[0] !== 6) begin n_fail++; $display("FAIL to_spacing: got %0d want 6", q_rr_c[1] - q_rr_c[0]); end
      end
      repeat (8) tick();
      n_cmp++; if (bus_rr.idle !== 1'b1 || q_rr_d.size() !== 2) begin n_fail++; $display("FAIL to_no_hang: got idle=%b starts=%0d want 1/2", bus_rr.idle, q_rr_d.size()); end
   endtask

   task automatic test_reset_mid_stream();
      int acc;
      bit ok;
      do_reset();
      r0v = 1'b1; r0d = 8'h51; tick();
      r0d = 8'h52; tick();
      r0d = 8'h53; tick();
      r0v = 1'b0;
      busy_force = 1'b1;
      tick(); tick();
      n_cmp++; if (q_rr_d.size() !== 1 || q_rr_d[0] !== 8'h51) begin n_fail++; $display("FAIL rst_first_launch: got %0d starts want 1 of 51", q_rr_d.size()); end
      n_cmp++; if (bus_rr.idle !== 1'b0) begin n_fail++; $display("FAIL rst_pre_idle: got %b want 0", bus_rr.idle); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++; if (bus_rr.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b want 0", bus_rr.tx_start); end
      n_cmp++; if (bus_rr.idle !== 1'b1 || bus_rr.req0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_flushed: got idle=%b ready=%b want 1/1", bus_rr.idle, bus_rr.req0_ready); end
      repeat (4) tick();
      busy_force = 1'b0;
      repeat (12) tick();
      n_cmp++; if (q_rr_d.size() !== 1) begin n_fail++; $display("FAIL rst_no_relaunch: got %0d starts want 1", q_rr_d.size()); end
      push0(8'h5A, acc);
      wait_rr(2, 20, ok);
      n_cmp++; if (!ok || q_rr_d[q_rr_d.size()-1] !== 8'h5A) begin n_fail++; $display("FAIL rst_new_push: got %0d starts want 2 ending 5a", q_rr_d.size()); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_contention();
      test_fixed_priority();
      test_backpressure();
      test_timeout();
      test_reset_mid_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UartTx byte transmitter between two byte producers: port 0 is the DMA/loader echo path and port 1 is the memory-controller output path. It replaces the OR-merge of tx_start/sdata. Each port gets its own small FIFO with a valid/ready handshake. The arbiter launches one byte at a time and tracks UartTx's tx_busy, so bytes are never dropped and requests never collide.

Parameters:
DEPTH, 4, entries per port FIFO; power of two, >= 2
ROUND_ROBIN, 1, 1 = alternate grants when both ports are pending; 0 = fixed priority, port 0 wins
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start before abandoning the wait

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
req0_valid  in  1  port 0 offers a byte
req0_data  in  8  port 0 byte
req0_ready  out  1  port 0 FIFO not full; byte accepted when valid && ready
req1_valid  in  1  port 1 offers a byte
req1_data  in  8  port 1 byte
req1_ready  out  1  port 1 FIFO not full
tx_busy  in  1  from UartTx, high while it is serialising
tx_start  out  1  one-cycle launch pulse to UartTx, registered
sdata  out  8  byte to UartTx, registered; stable from tx_start until return to IDLE
grant_id  out  1  port of the most recently launched byte
idle  out  1  high when both FIFOs are empty and the FSM is in IDLE

Behaviour:
- Reset values: tx_start=0, sdata=0, grant_id=0, req0_ready=1, req1_ready=1, idle=1, FSM=IDLE, both FIFOs empty, round-robin pointer favours port 0.
- FIFOs: one per port, DEPTH entries, with pointers one bit wider than the index for full/empty detection.
  - readyN = !fullN, driven from registered state.
  - A push and a pop on the same FIFO in the same cycle are both performed; count is unchanged. This is legal even when the FIFO is full, because ready is already low.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE: when tx_busy=0 and at least one FIFO is non-empty, choose a winner, pop its head into sdata, set grant_id, and go to START. With tx_busy=1, stay in IDLE.
  - START: tx_start=1 for exactly this cycle. Go to WAIT_BUSY with the timeout counter cleared.
  - WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Otherwise increment the counter; when it reaches BUSY_TIMEOUT, go to IDLE. The byte counts as sent and is not retried.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Arbitration:
  - With ROUND_ROBIN=1 and both ports pending, grant the port that was not granted last.
  - With only one port pending, grant that port regardless of mode.
  - With ROUND_ROBIN=0, port 0 always wins.
  - The pointer updates only on a grant.
- Latency: a byte accepted on edge k into an empty FIFO, with the FSM idle and tx_busy=0, gives tx_start high in cycle k+2.
- Back-to-back rate: the minimum spacing between tx_start pulses is 3 cycles plus the tx_busy high time.
- sdata changes only on the IDLE->START transition.
- Simultaneous events:
  - A push into an empty FIFO is not visible to the IDLE decision in the same cycle.
  - A push while the same port is being popped is accepted.
- Reset during an operation:
  - Both FIFOs are flushed and queued bytes are lost.
  - The FSM returns to IDLE and tx_start drops on the next edge.
  - A byte already in UartTx is not aborted by this block. After reset, no new byte launches until tx_busy=0.
- idle = (state==IDLE) && both FIFOs empty, registered-equivalent, with no combinational path from the req inputs.

Test Plan:
1. Single byte: req0 sends 0x41 once, tx_busy is modelled as high 2 cycles after start for 20 cycles -> one tx_start pulse in cycle k+2, sdata=0x41, grant_id=0, idle returns to 1 after tx_busy falls.
2. Contention, ROUND_ROBIN=1: both ports preload 3 bytes (port 0: 0x10..0x12, port 1: 0x20..0x22) -> UartTx receives 0x10,0x20,0x11,0x21,0x12,0x22; grant_id alternates 0,1,0,1,0,1.
3. Fixed priority, ROUND_ROBIN=0, same preload as test 2 -> 0x10,0x11,0x12,0x20,0x21,0x22.
4. Backpressure: tx_busy held high, port 1 pushes continuously -> exactly DEPTH=4 bytes accepted and req1_ready=0; release tx_busy -> all 4 bytes sent in order and ready returns to 1 after the first pop.
5. Timeout: tx_busy tied 0, port 0 sends 0xAA,0xBB -> two tx_start pulses, each followed by 4 WAIT_BUSY cycles; no hang.
6. Reset mid-stream: assert reset for 1 cycle while in WAIT_DONE with 2 bytes queued and tx_busy=1 -> FIFOs empty and tx_start=0. When tx_busy later falls, no further tx_start until a new push.
